// File: rtl/nand2_gate.sv
// Bitwise 2-input NAND cell: a combinational output, a registered copy, and
// sticky coverage of the bit-0 input patterns.

module nand2_lane (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic y,
    output logic y_q
);
    assign y = ~(a & b);

    // The reset value matches the NAND of idle-low inputs.
    always_ff @(posedge clk) begin
        if (rst) y_q <= 1'b1;
        else     y_q <= y;
    end
endmodule

module nand2_gate #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [3:0]       cov,
    output logic             cov_all
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nand2_lane u_lane (
            .clk (clk),
            .rst (rst),
            .a   (a[i]),
            .b   (b[i]),
            .y   (y[i]),
            .y_q (y_q[i])
        );
    end

    // Only bit 0 is tracked; the pattern {a,b} indexes the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) cov <= 4'b0000;
        else     cov[{a[0], b[0]}] <= 1'b1;
    end

    assign cov_all = &cov;
endmodule

// File: tb/tb_nand2_gate.sv
// Directed checks of nand2_gate at WIDTH=1 and WIDTH=8, plus a short random sweep.

module tb_nand2_gate;
    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, y1, yq1, all1;
    logic [3:0] cov1;
    logic [7:0] a8, b8, y8, yq8;
    logic [3:0] cov8;
    logic       all8;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    nand2_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .y(y1), .y_q(yq1), .cov(cov1), .cov_all(all1)
    );

    nand2_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8),
        .y(y8), .y_q(yq8), .cov(cov8), .cov_all(all8)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] pat [4];
    logic       ytt [4];

    initial begin
        pat = '{2'b00, 2'b01, 2'b10, 2'b11};
        ytt = '{1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        a8 = 8'h00; b8 = 8'h00;
        #1;
        chk("y_during_rst", {7'b0, y1}, 8'h00);
        tick();
        chk("rst_yq", {7'b0, yq1}, 8'h01);
        chk("rst_cov", {4'b0, cov1}, 8'h00);
        chk("rst_cov_all", {7'b0, all1}, 8'h00);
        chk("rst_y", {7'b0, y1}, 8'h00);
        chk("rst_yq8", yq8, 8'hFF);

        // Truth table, combinational only.
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = pat[i];
            #10;
            chk($sformatf("tt_%b", pat[i]), {7'b0, y1}, {7'b0, ytt[i]});
        end

        // Coverage build-up with registered output.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {a1, b1} = pat[i];
            tick();
            chk($sformatf("yq_%b", pat[i]), {7'b0, yq1}, {7'b0, ytt[i]});
        end
        chk("cov_0111", {4'b0, cov1}, 8'h07);
        chk("cov_all_0", {7'b0, all1}, 8'h00);
        {a1, b1} = 2'b11;
        tick();
        chk("yq_11", {7'b0, yq1}, 8'h00);
        chk("cov_1111", {4'b0, cov1}, 8'h0F);
        chk("cov_all_1", {7'b0, all1}, 8'h01);

        // 8-bit lanes.
        a8 = 8'hF0; b8 = 8'hCC;
        #1;
        chk("y8_comb", y8, 8'h3F);
        tick();
        chk("y8_reg", yq8, 8'h3F);

        // Reset mid-operation.
        a1 = 1'b0; b1 = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_cov", {4'b0, cov1}, 8'h00);
        chk("mid_rst_yq", {7'b0, yq1}, 8'h01);
        chk("mid_rst_yq8", yq8, 8'hFF);
        chk("mid_rst_y8", y8, 8'h3F);
        rst = 1'b0;
        tick();
        chk("cov_0001", {4'b0, cov1}, 8'h01);

        // Random sweep on the 8-bit instance.
        for (int i = 0; i < 300; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            #1;
            chk("rnd_y", y8, ~(a8 & b8));
            tick();
            chk("rnd_yq", yq8, ~(a8 & b8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
